// File: rtl/multdiv_pkg.sv
// rtl/multdiv_pkg.sv - shared state encoding and default step counts for the multdiv sequencer
package multdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int DEF_CNT_W      = 6;
  localparam int DEF_MULT_STEPS = 32;
  localparam int DEF_DIV_STEPS  = 32;

endpackage

// File: rtl/multdiv_iter_cnt.sv
// rtl/multdiv_iter_cnt.sv - synchronous-clear, enabled up-counter with terminal-count compare
module multdiv_iter_cnt #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             clear,
  input  logic             inc,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] cnt,
  output logic             terminal
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt      = cnt_q;
  assign terminal = (cnt_q == limit);

endmodule

// File: rtl/multdiv_sequencer.sv
// rtl/multdiv_sequencer.sv - load/step/done sequencer for the iterative multiply/divide datapath
// Optional MULTDIV_RESTART_EN: a start in any state aborts the current operation and restarts.
module multdiv_sequencer
  import multdiv_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int MULT_STEPS = DEF_MULT_STEPS,
  parameter int DIV_STEPS  = DEF_DIV_STEPS
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ctrl_mult,
  input  logic             ctrl_div,
  input  logic             divisor_zero,
  output logic             load,
  output logic             step_en,
  output logic             op_is_div,
  output logic [CNT_W-1:0] iter,
  output logic             stall,
  output logic             result_rdy,
  output logic             exception
);

  state_e state_q, state_d;
  logic   op_is_div_q, op_is_div_d;
  logic   exception_q, exception_d;
  logic   start, can_start, div_by_zero, terminal;
  logic [CNT_W-1:0] limit;

  assign start       = ctrl_mult | ctrl_div;
  assign div_by_zero = ctrl_div & ~ctrl_mult & divisor_zero;

`ifdef MULTDIV_RESTART_EN
  assign can_start = 1'b1;
`else
  assign can_start = (state_q == IDLE);
`endif

  always_comb begin
    state_d     = state_q;
    op_is_div_d = op_is_div_q;
    exception_d = 1'b0;
    if (start && can_start) begin
      op_is_div_d = ctrl_div & ~ctrl_mult;
      if (div_by_zero) begin
        // Nothing to iterate: report the exception straight away.
        state_d     = DONE;
        exception_d = 1'b1;
      end else begin
        state_d = LOAD;
      end
    end else begin
      case (state_q)
        LOAD:    state_d = RUN;
        RUN:     state_d = terminal ? DONE : RUN;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q     <= IDLE;
      op_is_div_q <= 1'b0;
      exception_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_is_div_q <= op_is_div_d;
      exception_q <= exception_d;
    end
  end

  assign load       = (state_q == LOAD);
  assign step_en    = (state_q == RUN);
  assign result_rdy = (state_q == DONE);
  assign exception  = exception_q;
  assign op_is_div  = op_is_div_q;
  assign stall      = ((state_q == IDLE) & start) | load | step_en;

  assign limit = op_is_div_q ? CNT_W'(DIV_STEPS - 1) : CNT_W'(MULT_STEPS - 1);

  // Hold at the last index instead of stepping past it.
  multdiv_iter_cnt #(.CNT_W(CNT_W)) u_iter_cnt (
    .clk      (clk),
    .clr      (clr),
    .clear    (load),
    .inc      (step_en & ~terminal),
    .limit    (limit),
    .cnt      (iter),
    .terminal (terminal)
  );

endmodule

// File: tb/tb_multdiv_sequencer.sv
// tb/tb_multdiv_sequencer.sv - randomized self-checking bench for multdiv_sequencer
module tb_multdiv_sequencer;

  localparam int CNT_W = 6;
  localparam int STEPS = 32;

  logic             clk = 1'b0;
  logic             clr = 1'b0;
  logic             ctrl_mult = 1'b0, ctrl_div = 1'b0, divisor_zero = 1'b0;
  logic             load, step_en, op_is_div, stall, result_rdy, exception;
  logic [CNT_W-1:0] iter;

  int n_cmp = 0;
  int n_err = 0;

  // Transaction-level reference: the last accepted operation and its start cycle.
  int cyc = 0;
  bit act = 0;
  int t0 = 0;
  bit m_div = 0;
  bit m_dz = 0;

  multdiv_sequencer #(.CNT_W(CNT_W), .MULT_STEPS(STEPS), .DIV_STEPS(STEPS)) dut (
    .clk          (clk),
    .clr          (clr),
    .ctrl_mult    (ctrl_mult),
    .ctrl_div     (ctrl_div),
    .divisor_zero (divisor_zero),
    .load         (load),
    .step_en      (step_en),
    .op_is_div    (op_is_div),
    .iter         (iter),
    .stall        (stall),
    .result_rdy   (result_rdy),
    .exception    (exception)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, got, exp);
    end
  endtask

  task automatic cycle(input bit m, input bit d, input bit z);
    int  dd, end_d;
    bit  idle, e_load, e_step, e_res, e_exc, e_stall, accept, restart;
    @(negedge clk);
    ctrl_mult = m; ctrl_div = d; divisor_zero = z;
    #1;
`ifdef MULTDIV_RESTART_EN
    restart = 1;
`else
    restart = 0;
`endif
    dd      = cyc - t0;
    end_d   = m_dz ? 1 : STEPS + 2;
    idle    = !act || dd > end_d;
    e_load  = act && !m_dz && dd == 1;
    e_step  = act && !m_dz && dd >= 2 && dd <= STEPS + 1;
    e_res   = act && dd == end_d;
    e_exc   = e_res && m_dz;
    e_stall = (idle && (m || d)) || e_load || e_step;
    check("load", int'(load), int'(e_load));
    check("step_en", int'(step_en), int'(e_step));
    check("result_rdy", int'(result_rdy), int'(e_res));
    check("exception", int'(exception), int'(e_exc));
    check("stall", int'(stall), int'(e_stall));
    check("op_is_div", int'(op_is_div), act ? int'(m_div) : 0);
    if (e_step) check("iter", int'(iter), dd - 2);
    accept = (m || d) && (restart || idle);
    if (accept) begin
      act   = 1;
      t0    = cyc;
      m_div = d && !m;
      m_dz  = d && !m && z;
    end
    cyc++;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr = 1'b0; ctrl_mult = 0; ctrl_div = 0; divisor_zero = 0;
    #1;
    act = 0; m_div = 0; m_dz = 0;
    for (int k = 0; k < 2; k++) begin
      check("rst_load", int'(load), 0);
      check("rst_step_en", int'(step_en), 0);
      check("rst_result_rdy", int'(result_rdy), 0);
      check("rst_exception", int'(exception), 0);
      check("rst_op_is_div", int'(op_is_div), 0);
      check("rst_iter", int'(iter), 0);
      check("rst_stall", int'(stall), 0);
      @(negedge clk);
      #1;
    end
    clr = 1'b1;
    cyc += 3;
  endtask

  initial begin
    do_reset();
    idle_cycles(3);
    // plain multiply
    cycle(1, 0, 0); idle_cycles(40);
    // divide by zero
    cycle(0, 1, 1); idle_cycles(4);
    // simultaneous mult and div: mult wins
    cycle(1, 1, 0); idle_cycles(40);
    // divide, then a mult request mid-operation
    cycle(0, 1, 0); idle_cycles(9); cycle(1, 0, 0); idle_cycles(45);
    // back-to-back: new multiply right after DONE
    cycle(1, 0, 0); idle_cycles(34); cycle(1, 0, 0); idle_cycles(40);
    // divisor_zero without ctrl_div is ignored
    cycle(1, 0, 1); idle_cycles(36);
    // reset during RUN drops the result
    cycle(0, 1, 0); idle_cycles(10);
    do_reset();
    idle_cycles(40);
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 9) == 0)
        cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else
        cycle(0, 0, 1'($urandom_range(0, 1)));
    end
    idle_cycles(40);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
